// File: rtl/exception_ctrl_seq_if.sv
// Redirect handshake between the exception sequencer (master) and fetch (slave).
// Latency: none, plain wires.
// Backpressure: master holds redirect_valid/redirect_pc until redirect_ready is sampled high.
interface exception_ctrl_seq_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/exception_ctrl_seq.sv
// Commit-stage exception/interrupt/ERET sequencer: CP0 commit pulse, timed flush, fetch redirect (EXC_VECTORED_INT_EN: vectored interrupts).
// Latency: commit pulse and flush one cycle after the accepted event; redirect after FLUSH_CYCLES of flush.
// Backpressure: redirect held stable until redirect_ready; commit requests are ignored while busy.
module exception_ctrl_seq #(
    parameter int          NUM_HW_INT      = 6,
    parameter int          SYNC_STAGES     = 2,
    parameter int          FLUSH_CYCLES    = 2,
    parameter logic [31:0] INT_VEC_SPACING = 32'h20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic [31:0]           status,
    input  logic [31:0]           cause,
    input  logic [31:0]           ebase,
    input  logic [31:0]           epc,
    input  logic [31:0]           errepc,
    input  logic                  commit_valid,
    input  logic [10:0]           exc_req,
    input  logic                  eret,
    input  logic                  load,
    input  logic                  in_delayslot,
    input  logic [31:0]           pc_current,
    input  logic [31:0]           data_address,
    output logic                  exc_commit,
    output logic                  eret_commit,
    output logic [4:0]            exc_code,
    output logic [31:0]           epc_out,
    output logic [31:0]           badvaddr_out,
    output logic                  badvaddr_we,
    output logic [18:0]           vpn2_out,
    output logic                  vpn2_we,
    output logic                  flush,
    output logic                  busy,
    output logic                  int_pending,
    exception_ctrl_seq_if.master  redir
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    // CP0 status/cause fields used here
    logic ie, exl, erl, bev, iv;
    assign ie  = status[0];
    assign exl = status[1];
    assign erl = status[2];
    assign bev = status[22];
    assign iv  = cause[23];

    // Index 0 is the first synchroniser flop, SYNC_STAGES-1 the one the logic uses.
    logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync_q;
    logic [5:0] hw_now;
    logic [5:0] hw_next;
    logic [7:0] pend;
    logic [7:0] pend_next;
    logic       int_take;

    // Hardware interrupt synchroniser chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hw_int};
        end
    end

    // Widen synchronised lines to the six IP[7:2] positions; absent lines read as 0
    always_comb begin
        hw_now  = '0;
        hw_next = '0;
        hw_now[NUM_HW_INT-1:0]  = sync_q[SYNC_STAGES-1];
        hw_next[NUM_HW_INT-1:0] = sync_q[SYNC_STAGES-2];
    end

    assign pend      = {hw_now, cause[9:8]} & status[15:8];
    assign pend_next = {hw_next, cause[9:8]} & status[15:8];
    assign int_take  = (|pend) & ie & ~exl & ~erl;

    // Interrupt offset (with IV=1) from the exception base
    logic [31:0] int_off;
`ifdef EXC_VECTORED_INT_EN
    logic [2:0] int_idx;

    // Highest pending enabled IP index selects the vector
    always_comb begin
        int_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) int_idx = 3'(i);
        end
        int_off = 32'h200 + 32'(int_idx) * INT_VEC_SPACING;
    end

    logic unused_bits;
    assign unused_bits = ^{status[31:23], status[21:16], status[7:3],
                           cause[31:24], cause[22:10], cause[7:0],
                           ebase[31:30], ebase[11:0]};
`else
    assign int_off = 32'h200;

    logic unused_bits;
    assign unused_bits = ^{status[31:23], status[21:16], status[7:3],
                           cause[31:24], cause[22:10], cause[7:0],
                           ebase[31:30], ebase[11:0], INT_VEC_SPACING};
`endif

    // Decoded result of the request at commit
    logic        is_exc;
    logic        is_int;
    logic        is_refill;
    logic [4:0]  code_c;
    logic        bad_we_c;
    logic        vpn_we_c;
    logic [31:0] bad_addr_c;
    logic [31:0] base_c;
    logic [31:0] off_c;
    logic [31:0] exc_target;
    logic [31:0] eret_target;
    logic [31:0] epc_calc;
    logic        take_event;

    // Priority encode interrupt/exception cause, fault address and vector target
    always_comb begin
        is_int     = 1'b0;
        is_refill  = 1'b0;
        code_c     = 5'd0;
        bad_we_c   = 1'b0;
        vpn_we_c   = 1'b0;
        bad_addr_c = 32'h0;
        if (int_take) begin
            is_int = 1'b1;
            code_c = 5'd0;
        end else if (exc_req[0]) begin          // ade_i
            code_c     = 5'd4;
            bad_we_c   = 1'b1;
            bad_addr_c = pc_current;
        end else if (exc_req[1]) begin          // tlbrefill_i
            code_c     = 5'd2;
            bad_we_c   = 1'b1;
            vpn_we_c   = 1'b1;
            bad_addr_c = pc_current;
            is_refill  = 1'b1;
        end else if (exc_req[2]) begin          // tlbinv_i
            code_c     = 5'd2;
            bad_we_c   = 1'b1;
            vpn_we_c   = 1'b1;
            bad_addr_c = pc_current;
        end else if (exc_req[3]) begin          // ri
            code_c = 5'd10;
        end else if (exc_req[5]) begin          // sys
            code_c = 5'd8;
        end else if (exc_req[6]) begin          // bp
            code_c = 5'd9;
        end else if (exc_req[4]) begin          // ov
            code_c = 5'd12;
        end else if (exc_req[7]) begin          // ade_d
            code_c     = load ? 5'd4 : 5'd5;
            bad_we_c   = 1'b1;
            bad_addr_c = data_address;
        end else if (exc_req[8]) begin          // tlbrefill_d
            code_c     = load ? 5'd2 : 5'd3;
            bad_we_c   = 1'b1;
            vpn_we_c   = 1'b1;
            bad_addr_c = data_address;
            is_refill  = 1'b1;
        end else if (exc_req[9]) begin          // tlbinv_d
            code_c     = load ? 5'd2 : 5'd3;
            bad_we_c   = 1'b1;
            vpn_we_c   = 1'b1;
            bad_addr_c = data_address;
        end else if (exc_req[10]) begin         // mod
            code_c     = 5'd1;
            bad_we_c   = 1'b1;
            vpn_we_c   = 1'b1;
            bad_addr_c = data_address;
        end

        is_exc = int_take | (|exc_req);

        base_c = bev ? 32'hBFC0_0200 : {2'b10, ebase[29:12], 12'h000};
        if (is_refill && !exl) begin
            off_c = 32'h000;
        end else if (is_int && iv) begin
            off_c = int_off;
        end else begin
            off_c = 32'h180;
        end
        exc_target  = base_c + off_c;
        eret_target = erl ? errepc : epc;
        epc_calc    = in_delayslot ? (pc_current - 32'd4) : pc_current;
        take_event  = commit_valid & (is_exc | eret);
    end

    // Sequencer: IDLE -> FLUSH -> REDIRECT -> IDLE; commit outputs live for one cycle only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            flush_cnt        <= '0;
            busy             <= 1'b0;
            flush            <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            exc_commit       <= 1'b0;
            eret_commit      <= 1'b0;
            exc_code         <= '0;
            epc_out          <= '0;
            badvaddr_out     <= '0;
            badvaddr_we      <= 1'b0;
            vpn2_out         <= '0;
            vpn2_we          <= 1'b0;
        end else begin
            exc_commit   <= 1'b0;
            eret_commit  <= 1'b0;
            exc_code     <= '0;
            epc_out      <= '0;
            badvaddr_out <= '0;
            badvaddr_we  <= 1'b0;
            vpn2_out     <= '0;
            vpn2_we      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_event) begin
                        state     <= ST_FLUSH;
                        busy      <= 1'b1;
                        flush     <= 1'b1;
                        flush_cnt <= FLUSH_INIT;
                        if (is_exc) begin
                            redirect_pc_q <= exc_target;
                            exc_commit    <= 1'b1;
                            exc_code      <= code_c;
                            epc_out       <= epc_calc;
                            badvaddr_out  <= bad_we_c ? bad_addr_c : 32'h0;
                            badvaddr_we   <= bad_we_c;
                            vpn2_out      <= vpn_we_c ? bad_addr_c[31:13] : 19'h0;
                            vpn2_we       <= vpn_we_c;
                        end else begin
                            redirect_pc_q <= eret_target;
                            eret_commit   <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state            <= ST_REDIRECT;
                        flush            <= 1'b0;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (redir.redirect_ready) begin
                        state            <= ST_IDLE;
                        busy             <= 1'b0;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    busy             <= 1'b0;
                    flush            <= 1'b0;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Pending flag computed from the value entering the last sync flop so it lines up with int_take
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_pending <= 1'b0;
        end else begin
            int_pending <= |pend_next;
        end
    end

    assign redir.redirect_valid = redirect_valid_q;
    assign redir.redirect_pc    = redirect_pc_q;

endmodule
